// File: rtl/chip8_scanout.sv
// Chip-8 / XO-Chip framebuffer scan-out: prefetches each scaled source row into a
// two-plane line buffer during blanking, then maps pixels through an RGB332 palette.
module chip8_scanout #(
    parameter int PLANES       = 2,
    parameter int FB_AW        = 10,
    parameter int PLANE_STRIDE = 512,
    parameter int V_START      = 48,
    parameter int V_ACTIVE     = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hires,
    input  logic [PLANES-1:0] planeMask,
    input  logic              pixelEnable,
    input  logic [10:0]       pixelX,
    input  logic [10:0]       pixelY,
    input  logic              frameStart,
    input  logic              lineStart,
    output logic [FB_AW-1:0]  fbAddr,
    input  logic [15:0]       fbData,
    input  logic              palWe,
    input  logic [1:0]        palIdx,
    input  logic [7:0]        palData,
    output logic [2:0]        r,
    output logic [2:0]        g,
    output logic [1:0]        b,
    output logic              outsidePlayfield,
    output logic              fetchBusy,
    output logic              underrun
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetchState_e;

    fetchState_e       state, stateNext;
    logic              hiresLat;
    logic [PLANES-1:0] maskLat;
    logic [1:0]        maskEff;
    logic [2:0]        wordLast;
    logic [3:0]        wordsPerRow, hLast, vLast;
    logic [6:0]        colMax, row, col, fetchRow;
    logic [3:0]        vSub, hSub, bitSel;
    logic              inPlay_p0, pixVld_p0, startFetch, lastIssue, firstPlane;
    logic              addrPlane, capPlane, capVld;
    logic [2:0]        addrWord, capWord;
    logic [1:0]        colIdx_p0;
    logic [15:0]       lineBuf [2][8];
    logic [7:0]        palette [4];
    logic [7:0]        rgb_p1;
    logic              unusedPixelX;

    function automatic logic [FB_AW-1:0] fetchAddr(input logic plane, input logic [6:0] rowIdx,
                                                   input logic [2:0] word, input logic [3:0] words);
        logic [31:0] a;
        a = 32'(plane) * 32'(PLANE_STRIDE) + 32'(rowIdx) * 32'(words) + 32'(word);
        return a[FB_AW-1:0];
    endfunction

    function automatic logic [6:0] satColInc(input logic [6:0] c, input logic [6:0] cMax);
        return (c >= cMax) ? cMax : c + 7'd1;
    endfunction

    // Column position is derived from counted pixelEnable strobes, not the beam X.
    assign unusedPixelX = ^pixelX;

    always_comb begin
        maskEff = '0;
        maskEff[PLANES-1:0] = maskLat;
    end

    assign wordLast    = hiresLat ? 3'd7 : 3'd3;
    assign wordsPerRow = hiresLat ? 4'd8 : 4'd4;
    assign hLast       = hiresLat ? 4'd4 : 4'd9;
    assign vLast       = hiresLat ? 4'd5 : 4'd11;
    assign colMax      = hiresLat ? 7'd127 : 7'd63;

    assign inPlay_p0        = (int'(pixelY) >= V_START) && (int'(pixelY) < V_START + 384);
    assign outsidePlayfield = !inPlay_p0;
    assign pixVld_p0        = pixelEnable && inPlay_p0;

    assign startFetch = lineStart && !frameStart && inPlay_p0 && (vSub == 4'd0) && (maskEff != 2'b00);
    assign firstPlane = !maskEff[0];
    assign lastIssue  = (addrWord == wordLast) && !((addrPlane == 1'b0) && maskEff[1]);
    assign fetchBusy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            hiresLat <= 1'b0;
            maskLat  <= '1;
            row      <= '0;
            vSub     <= '0;
        end else if (frameStart) begin
            hiresLat <= hires;
            maskLat  <= planeMask;
            row      <= '0;
            vSub     <= '0;
        end else if (lineStart && inPlay_p0) begin
            if (vSub == vLast) begin
                vSub <= '0;
                row  <= row + 7'd1;
            end else begin
                vSub <= vSub + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startFetch) stateNext = FETCH;
            FETCH:   if (lastIssue) stateNext = DRAIN;
            DRAIN:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (frameStart) stateNext = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fbAddr    <= '0;
            addrPlane <= 1'b0;
            addrWord  <= '0;
            capVld    <= 1'b0;
        end else begin
            capVld <= (state == FETCH) && !frameStart;
            if (state == IDLE && stateNext == FETCH) begin
                addrPlane <= firstPlane;
                addrWord  <= '0;
                fbAddr    <= fetchAddr(firstPlane, row, 3'd0, wordsPerRow);
            end else if (state == FETCH && stateNext == FETCH) begin
                if (addrWord == wordLast) begin
                    addrPlane <= 1'b1;
                    addrWord  <= '0;
                    fbAddr    <= fetchAddr(1'b1, fetchRow, 3'd0, wordsPerRow);
                end else begin
                    addrWord <= addrWord + 3'd1;
                    fbAddr   <= fetchAddr(addrPlane, fetchRow, addrWord + 3'd1, wordsPerRow);
                end
            end
        end
    end

    // Read data trails the address by one cycle, so the slot tag is delayed to match.
    always_ff @(posedge clk) begin
        if (state == IDLE) fetchRow <= row;
        capPlane <= addrPlane;
        capWord  <= addrWord;
        if (capVld) lineBuf[capPlane][capWord] <= fbData;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col  <= '0;
            hSub <= '0;
        end else if (lineStart) begin
            col  <= '0;
            hSub <= '0;
        end else if (pixVld_p0) begin
            if (hSub == hLast) begin
                hSub <= '0;
                col  <= satColInc(col, colMax);
            end else begin
                hSub <= hSub + 4'd1;
            end
        end
    end

    assign bitSel       = 4'd15 - col[3:0];
    assign colIdx_p0[0] = lineBuf[0][col[6:4]][bitSel] & maskEff[0];
    assign colIdx_p0[1] = lineBuf[1][col[6:4]][bitSel] & maskEff[1];

    // p0 -> p1: palette lookup and border override registered onto r/g/b.
    always_ff @(posedge clk) begin
        if (reset) begin
            palette[0] <= 8'h6D;
            palette[1] <= 8'hD9;
            palette[2] <= 8'hE0;
            palette[3] <= 8'hFC;
            rgb_p1     <= '0;
            underrun   <= 1'b0;
        end else begin
            if (palWe) palette[palIdx] <= palData;
            if (pixelEnable && (pixelY == 11'd0 || pixelY == 11'(V_ACTIVE - 1))) rgb_p1 <= 8'hFF;
            else if (pixVld_p0)                                                 rgb_p1 <= palette[colIdx_p0];
            else                                                                rgb_p1 <= 8'h00;
            if (pixVld_p0 && fetchBusy) underrun <= 1'b1;
        end
    end

    assign {r, g, b} = rgb_p1;

endmodule

// File: tb/tb_chip8_scanout.sv
// Bench for chip8_scanout: randomized frames against a geometry/palette reference
// model, with a pixel scoreboard plus directed fetch, palette, underrun and reset cases.
module tb_chip8_scanout;

    localparam int PLANES = 2, FB_AW = 10, PLANE_STRIDE = 512, V_START = 48, V_ACTIVE = 480;

    logic              clk = 1'b0;
    logic              reset, hires, pixelEnable, frameStart, lineStart, palWe;
    logic [PLANES-1:0] planeMask;
    logic [10:0]       pixelX, pixelY;
    logic [FB_AW-1:0]  fbAddr;
    logic [15:0]       fbData;
    logic [1:0]        palIdx;
    logic [7:0]        palData;
    logic [2:0]        r, g;
    logic [1:0]        b;
    logic              outsidePlayfield, fetchBusy, underrun;

    chip8_scanout #(.PLANES(PLANES), .FB_AW(FB_AW), .PLANE_STRIDE(PLANE_STRIDE),
                    .V_START(V_START), .V_ACTIVE(V_ACTIVE)) dut (
        .clk(clk), .reset(reset), .hires(hires), .planeMask(planeMask),
        .pixelEnable(pixelEnable), .pixelX(pixelX), .pixelY(pixelY),
        .frameStart(frameStart), .lineStart(lineStart), .fbAddr(fbAddr), .fbData(fbData),
        .palWe(palWe), .palIdx(palIdx), .palData(palData), .r(r), .g(g), .b(b),
        .outsidePlayfield(outsidePlayfield), .fetchBusy(fetchBusy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    logic [15:0] fbMem [1024];
    always @(posedge clk) fbData <= fbMem[fbAddr];

    int         nComp = 0, nFail = 0;
    logic [8:0] expQ [$];
    logic       mHires;
    logic [1:0] mMask;
    logic [7:0] mPal [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nComp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference colour from frame geometry: row/column by division, bits from memory.
    function automatic logic [7:0] expColour(input int y, input int x);
        int W, vM, hM, row, c;
        logic [1:0]  idx;
        logic [15:0] wd;
        if (y == 0 || y == V_ACTIVE - 1) return 8'hFF;
        if (y < V_START || y >= V_START + 384) return 8'h00;
        W = mHires ? 8 : 4; vM = mHires ? 6 : 12; hM = mHires ? 5 : 10;
        row = (y - V_START) / vM;
        c = x / hM;
        if (c > W * 16 - 1) c = W * 16 - 1;
        idx = 2'b00;
        for (int p = 0; p < 2; p++) begin
            if (mMask[p]) begin
                wd = fbMem[p * PLANE_STRIDE + row * W + c / 16];
                idx[p] = wd[15 - c % 16];
            end
        end
        return mPal[idx];
    endfunction

    initial begin : monitor
        logic       pe;
        logic [8:0] e;
        forever begin
            @(posedge clk);
            pe = pixelEnable;
            #1;
            if (pe) begin
                if (expQ.size() == 0) begin
                    nComp++;
                    nFail++;
                    $display("FAIL pixel_queue: got pixel 0x%0h, required a queued expectation", {r, g, b});
                end else begin
                    e = expQ.pop_front();
                    if (!e[8]) check("pixel", {r, g, b}, e[7:0]);
                end
            end
        end
    end

    task automatic idle();
        pixelEnable = 1'b0; lineStart = 1'b0; frameStart = 1'b0; palWe = 1'b0;
    endtask

    task automatic modelReset();
        mHires = 1'b0; mMask = 2'b11;
        mPal = '{8'h6D, 8'hD9, 8'hE0, 8'hFC};
    endtask

    task automatic applyReset();
        @(negedge clk); idle(); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        modelReset();
    endtask

    task automatic startFrame(input bit h, input logic [1:0] m);
        @(negedge clk); idle();
        hires = h; planeMask = m; frameStart = 1'b1;
        mHires = h; mMask = m;
        @(negedge clk); frameStart = 1'b0;
        hires = ~h; planeMask = ~m;
    endtask

    task automatic palWrite(input logic [1:0] i, input logic [7:0] d);
        @(negedge clk); idle(); palWe = 1'b1; palIdx = i; palData = d;
        mPal[i] = d;
        @(negedge clk); palWe = 1'b0;
    endtask

    // One scan line: lineStart, watch the fetch for `gap` cycles, then `npix` pixels.
    task automatic doLine(input int y, input int gap, input int npix, input bit palRand);
        int W, vM, row, busy;
        int expA [$];
        int addrs [$];
        @(negedge clk); idle();
        lineStart = 1'b1; pixelY = 11'(y); pixelX = '0;
        W = mHires ? 8 : 4; vM = mHires ? 6 : 12;
        if (y >= V_START && y < V_START + 384 && ((y - V_START) % vM) == 0) begin
            row = (y - V_START) / vM;
            for (int p = 0; p < 2; p++)
                if (mMask[p])
                    for (int w = 0; w < W; w++) expA.push_back((p * PLANE_STRIDE + row * W + w) % 1024);
        end
        @(negedge clk); lineStart = 1'b0;
        busy = 0;
        for (int c = 0; c < gap; c++) begin
            if (fetchBusy) begin
                busy++;
                addrs.push_back(int'(fbAddr));
            end
            @(negedge clk);
        end
        check($sformatf("busy_cycles_y%0d", y), busy, (expA.size() > 0) ? expA.size() + 1 : 0);
        for (int i = 0; i < expA.size(); i++)
            check($sformatf("fbAddr_y%0d_%0d", y, i), (i < addrs.size()) ? addrs[i] : 32'hFFFF_FFFF, expA[i]);
        for (int i = 0; i < npix; ) begin
            pixelEnable = ($urandom_range(0, 7) != 0);
            pixelX = 11'(i);
            palWe = palRand && ($urandom_range(0, 11) == 0);
            palIdx = 2'($urandom_range(0, 3));
            palData = 8'($urandom);
            if (pixelEnable) begin
                expQ.push_back({1'b0, expColour(y, i)});
                i++;
            end
            if (palWe) mPal[palIdx] = palData;
            @(negedge clk);
        end
        idle();
    endtask

    task automatic randomFrame(input bit h, input logic [1:0] m);
        int np;
        for (int i = 0; i < 1024; i++) fbMem[i] = 16'($urandom);
        startFrame(h, m);
        doLine(0, 40, 24, 1);
        doLine(1, 40, 8, 1);
        doLine(V_START - 1, 40, 8, 1);
        for (int y = V_START; y < V_START + 384; y++) begin
            np = ($urandom_range(0, 15) == 0) ? int'($urandom_range(16, 96)) : 0;
            if (y == V_START || y == V_START + 383) np = 48;
            if (y == V_START + 100) np = 640;
            doLine(y, (np > 0) ? 40 : 20, np, 1);
        end
        doLine(V_START + 384, 40, 16, 1);
        doLine(V_ACTIVE - 1, 40, 24, 1);
        check("no_underrun_in_frame", underrun, 1'b0);
    endtask

    initial begin : stimulus
        int ys [6];
        ys = '{0, 47, 48, 431, 432, 479};
        idle(); reset = 1'b1; hires = 1'b0; planeMask = '0;
        pixelX = '0; pixelY = '0; palIdx = '0; palData = '0;
        for (int i = 0; i < 1024; i++) fbMem[i] = '0;
        modelReset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_rgb", {r, g, b}, 8'h00);
        check("rst_fbAddr", fbAddr, '0);
        check("rst_fetchBusy", fetchBusy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pixelY = 11'(ys[i]);
            #1;
            check($sformatf("outsidePlayfield_y%0d", ys[i]), outsidePlayfield,
                  (ys[i] < V_START || ys[i] >= V_START + 384) ? 1'b1 : 1'b0);
        end

        // Lores, plane 0 only, single set pixel in word 0 of row 0.
        fbMem[0] = 16'h8000;
        startFrame(1'b0, 2'b01);
        doLine(V_START, 40, 20, 0);

        // Hires, both planes, row 1 fetched on line V_START+6.
        for (int i = 0; i < 1024; i++) fbMem[i] = '0;
        fbMem[8] = 16'h8000; fbMem[520] = 16'h8000;
        startFrame(1'b1, 2'b11);
        for (int y = V_START; y < V_START + 6; y++) doLine(y, 20, 0, 0);
        doLine(V_START + 6, 40, 12, 0);

        // Palette write, then a write colliding with a lookup of the same index.
        fbMem[0] = 16'h8000;
        palWrite(2'd1, 8'h1C);
        startFrame(1'b0, 2'b01);
        doLine(V_START, 40, 12, 0);
        doLine(V_START + 1, 40, 0, 0);
        @(negedge clk);
        pixelEnable = 1'b1; pixelX = 11'd0; palWe = 1'b1; palIdx = 2'd1; palData = 8'h03;
        expQ.push_back({1'b0, expColour(V_START + 1, 0)});
        mPal[1] = 8'h03;
        @(negedge clk);
        palWe = 1'b0; pixelX = 11'd1;
        expQ.push_back({1'b0, expColour(V_START + 1, 1)});
        @(negedge clk); idle();

        randomFrame(1'b0, 2'b11);
        randomFrame(1'b1, 2'b10);
        randomFrame(1'b1, 2'b00);

        // Pixel during an active fetch.
        startFrame(1'b0, 2'b11);
        @(negedge clk); idle(); lineStart = 1'b1; pixelY = 11'(V_START);
        @(negedge clk); lineStart = 1'b0;
        repeat (4) @(negedge clk);
        pixelEnable = 1'b1; pixelX = 11'd0;
        expQ.push_back(9'h100);
        @(negedge clk); idle();
        check("underrun_set", underrun, 1'b1);
        repeat (20) @(negedge clk);
        startFrame(1'b1, 2'b01);
        check("underrun_sticky_frame", underrun, 1'b1);
        applyReset();
        check("underrun_cleared", underrun, 1'b0);

        // Reset in the middle of a fetch.
        startFrame(1'b1, 2'b11);
        @(negedge clk); idle(); lineStart = 1'b1; pixelY = 11'(V_START);
        @(negedge clk); lineStart = 1'b0;
        @(negedge clk);
        check("busy_before_reset", fetchBusy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midfetch_rst_busy", fetchBusy, 1'b0);
        check("midfetch_rst_fbAddr", fbAddr, '0);
        check("midfetch_rst_rgb", {r, g, b}, 8'h00);
        reset = 1'b0;
        modelReset();

        repeat (3) @(negedge clk);
        check("queue_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nComp, nFail);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        nFail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", nComp, nFail);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/chip8_scanout.md
# chip8_scanout

Parametrised framebuffer scan-out engine for the Chip-8 video path, sitting between the VGA timing generator and the framebuffer RAM. It supports 1 or 2 bitplanes (XO-Chip style 4-colour), runtime lores/hires scaling and a writable RGB332 palette. Each scaled source row is prefetched into an internal line buffer during horizontal blanking, so the framebuffer port is idle during active pixels.

## Interface
- `PLANES`, 2: bitplane count, 1 or 2.
- `FB_AW`, 10: framebuffer word-address width.
- `PLANE_STRIDE`, 512: word offset between plane bases; plane p base = p*PLANE_STRIDE.
- `V_START`, 48: first playfield line.
- `V_ACTIVE`, 480: visible lines; lines 0 and V_ACTIVE-1 are border lines.
- `clk  in  1`: pixel-domain clock. One clock; reset is synchronous and active-high.
- `reset  in  1`: synchronous, active-high.
- `hires  in  1`: 1 = 128x64 at 5x6 scaling; 0 = 64x32 at 10x12 scaling. Sampled only on `frameStart`.
- `planeMask  in  PLANES`: enabled planes. Sampled on `frameStart`.
- `pixelEnable  in  1`: active-video pixel strobe.
- `pixelX, pixelY  in  11 each`: current beam position. `pixelY` already holds the new line's value in the `lineStart` cycle.
- `frameStart  in  1`: one-cycle pulse before the first line.
- `lineStart  in  1`: one-cycle pulse at the start of each line's blanking, at least 40 cycles before the first `pixelEnable` of that line.
- `fbAddr  out  FB_AW`: registered read address.
- `fbData  in  16`: read data, valid exactly 1 cycle after `fbAddr`. MSB is the leftmost pixel.
- `palWe  in  1`, `palIdx  in  2`, `palData  in  8`: palette write port, RGB332.
- `r  out  3`, `g  out  3`, `b  out  2`: registered colour.
- `outsidePlayfield  out  1`: combinational; !(V_START <= pixelY < V_START + 384).
- `fetchBusy  out  1`: a line fetch is in progress.
- `underrun  out  1`: sticky; cleared only by `reset`.

## Operation
- **Geometry latched at `frameStart`.**
  - Words per row W = 8 (hires) or 4 (lores).
  - hMult = 5 or 10; vMult = 6 or 12.
  - Playfield is 640 x 384 in both modes, starting at pixelX = 0 and pixelY = V_START.
- **Vertical state.** `frameStart` clears row to 0 and vSub to 0, and aborts any fetch (returns to IDLE). On `lineStart` with pixelY in the playfield:
  - If vSub == 0, start a fetch of the current row.
  - Then vSub advances; on reaching vMult-1 it wraps to 0 and row increments (7-bit).
- **Fetch FSM, IDLE -> FETCH -> DRAIN -> IDLE.**
  - FETCH issues one address per cycle: enabled planes in ascending order, words 0..W-1. Address = p*PLANE_STRIDE + row*W + w, truncated to FB_AW bits.
  - DRAIN captures the final word.
  - Each returned word is written to line-buffer slot [p][w].
  - Slots of disabled planes are forced to 0.
  - Line buffer is 2 planes x 8 words x 16 bits.
- **Horizontal.**
  - On `lineStart`, clear col (0..127) and hSub.
  - Each `pixelEnable` with pixelY in the playfield: sample bit col of each plane, then hSub increments. At hMult-1, hSub wraps to 0 and col increments; col saturates at W*16-1.
- **Colour index** = {plane1 bit, plane0 bit}; plane1 bit = 0 when PLANES = 1.
- **Output, registered on every cycle:**
  - `pixelEnable` with pixelY = 0 or V_ACTIVE-1: 8'hFF.
  - `pixelEnable` in the playfield: palette[index].
  - Otherwise: 8'h00.
- **Palette reset values:** 0 = 8'h6D, 1 = 8'hD9, 2 = 8'hE0, 3 = 8'hFC. A write takes effect for pixels sampled in the following cycle; a same-cycle lookup of the written index uses the old value.
- **Underrun:** `pixelEnable` in the playfield while `fetchBusy` = 1 sets `underrun`. The pixel is still output from the current buffer contents.

## Timing
- **Reset values:**
  - `fbAddr` = 0, `{r,g,b}` = 0, `fetchBusy` = 0, `underrun` = 0.
  - FSM in IDLE; row, vSub, col and hSub = 0; palette at its reset values.
  - Geometry = lores with all planes enabled, until the first `frameStart`.
- **Fetch timing.** For a fetch started by `lineStart` in cycle k, with N = W x (enabled planes):
  - `fbAddr` carries the addresses in cycles k+1 .. k+N.
  - Data is captured in cycles k+2 .. k+N+1.
  - `fetchBusy` = 1 for cycles k+1 .. k+N+1.
  - Worst case is N = 16, i.e. 17 busy cycles.
- **Pixel latency:** 1 cycle. The colour for a `pixelEnable` in cycle t appears on r/g/b in t+1.
- **No enabled planes:** no fetch cycles; `fetchBusy` stays 0 and every playfield pixel uses index 0.
- **Simultaneous `frameStart` and `lineStart`:** `frameStart` wins; no fetch starts.
- **`reset` mid-fetch:** the FSM returns to IDLE next cycle; the line-buffer contents are don't-care.

## Test plan
- **Lores, plane 0 only, word 0 of row 0 = 16'h8000:** line V_START shows palette 1 (8'hD9) for pixelX 0..9 and 8'h6D from pixelX 10; `fbAddr` sequence is 0,1,2,3.
- **Hires, 2 planes, row 1, plane1 word 0 = 16'h8000, plane0 word 0 = 16'h8000:** the fetch on line V_START+6 issues addresses 8..15, then 520..527; pixels 0..4 output 8'hFC; `fetchBusy` is high for 17 cycles.
- **Vertical scaling:** with lores, rows change at lines 48, 60, 72; only lines 48, 60, ... produce fetches; line 431 is the last playfield line; line 432 outputs 0.
- **Palette:** write idx 1 = 8'h1C, then scan a set pixel -> output 8'h1C. A write to idx 1 in the same cycle as an idx-1 lookup -> the old value is output.
- **Underrun:** assert `pixelEnable` at pixelY = 48 five cycles after `lineStart` -> `underrun` = 1, held through the next `frameStart`, cleared by `reset`.
- **Borders and reset:** pixelY = 0 and 479 with `pixelEnable` -> 8'hFF. Assert `reset` mid-fetch -> `fetchBusy` = 0 and `fbAddr` = 0 next cycle.
